seg_scan_capture: RTL and testbench

- Receive side of the multiplexed 7-segment bus (seg_sel/seg_data) driven by the display scanner.
- Samples the bus, deglitches each digit dwell, and decodes each segment pattern back to a 4-bit hex value.
- Assembles the four digits of one scan frame and presents them as a 16-bit word with a frame strobe.
- Used for loopback self-check of the counter/display path, both on-board and in simulation.

---
 rtl/seg_scan_capture.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: deglitches each digit dwell,
// decodes the segment pattern to hex and assembles four digits into a frame word.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  seg_sel,
  input  logic [6:0]  seg_data,
  output logic [15:0] digit_data,
  output logic        frame_valid,
  output logic        frame_changed,
  output logic        err_pattern,
  output logic        err_select,
  output logic        link_lost
);

  localparam int SC_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
  localparam logic [SC_W-1:0] SC_HIT = SC_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_HIT = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_STABLE, CAPTURED} state_t;

  // Returns {valid, value}; active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [4:0] decode_seg(input logic [6:0] pat);
    case (pat)
      7'h40: return 5'h10;
      7'h79: return 5'h11;
      7'h24: return 5'h12;
      7'h30: return 5'h13;
      7'h19: return 5'h14;
      7'h12: return 5'h15;
      7'h02: return 5'h16;
      7'h78: return 5'h17;
      7'h00: return 5'h18;
      7'h10: return 5'h19;
      7'h08: return 5'h1A;
      7'h03: return 5'h1B;
      7'h46: return 5'h1C;
      7'h21: return 5'h1D;
      7'h06: return 5'h1E;
      7'h0E: return 5'h1F;
      default: return 5'h00;
    endcase
  endfunction

  // Returns {legal, digit index}; only a single low bit in [3:0] with [5:4] high is legal.
  function automatic logic [2:0] decode_sel(input logic [5:0] sel);
    case (sel)
      6'h3E: return 3'b100;
      6'h3D: return 3'b101;
      6'h3B: return 3'b110;
      6'h37: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  logic [12:0]     s_reg_p0, s_prev_p1;
  logic [SC_W-1:0] stab_cnt;
  logic [TO_W-1:0] to_cnt;
  state_t          state, state_nxt;
  logic [3:0]      mask, mask_set;
  logic [15:0]     slots, slots_nxt;
  logic [2:0]      sel_dec;
  logic [4:0]      seg_dec;
  logic            same, blank, capture;
  logic            cap_ok, cap_badpat, cap_badsel, frame_done, timeout_hit;

  assign same    = (s_reg_p0 == s_prev_p1);
  assign blank   = (s_reg_p0[12:7] == 6'h3F);
  assign sel_dec = decode_sel(s_reg_p0[12:7]);
  assign seg_dec = decode_seg(s_reg_p0[6:0]);

  // A capture needs STABLE_CYCLES matching pairs, i.e. STABLE_CYCLES+1 identical samples.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: if (!blank) state_nxt = WAIT_STABLE;
      WAIT_STABLE: begin
        if (blank) begin
          state_nxt = IDLE;
        end else if (same && stab_cnt == SC_HIT) begin
          capture   = 1'b1;
          state_nxt = CAPTURED;
        end
      end
      CAPTURED: if (!same) state_nxt = blank ? IDLE : WAIT_STABLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cap_ok     = capture && sel_dec[2] && seg_dec[4];
    cap_badpat = capture && sel_dec[2] && !seg_dec[4];
    cap_badsel = capture && !sel_dec[2];
    slots_nxt  = slots;
    mask_set   = mask;
    if (cap_ok) begin
      slots_nxt[{sel_dec[1:0], 2'b00} +: 4] = seg_dec[3:0];
      mask_set = mask | (4'b0001 << sel_dec[1:0]);
    end
    frame_done  = cap_ok && (mask_set == 4'hF);
    timeout_hit = !cap_ok && (to_cnt == TO_HIT);
  end

  // Stage p0: bus sample; stage p1: previous sample plus capture bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg_p0      <= '1;
      s_prev_p1     <= '1;
      stab_cnt      <= '0;
      to_cnt        <= '0;
      state         <= IDLE;
      mask          <= '0;
      digit_data    <= '0;
      frame_valid   <= 1'b0;
      frame_changed <= 1'b0;
      err_pattern   <= 1'b0;
      err_select    <= 1'b0;
      link_lost     <= 1'b0;
    end else begin
      s_reg_p0      <= {seg_sel, seg_data};
      s_prev_p1     <= s_reg_p0;
      state         <= state_nxt;
      err_pattern   <= cap_badpat;
      err_select    <= cap_badsel;
      frame_valid   <= frame_done;
      frame_changed <= frame_done && (slots_nxt != digit_data);
      if (!same)
        stab_cnt <= '0;
      else if (stab_cnt != SC_MAX)
        stab_cnt <= stab_cnt + SC_W'(1);
      if (cap_ok)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + TO_W'(1);
      if (frame_done) begin
        mask       <= '0;
        digit_data <= slots_nxt;
        link_lost  <= 1'b0;
      end else if (cap_ok) begin
        mask <= mask_set;
      end else if (timeout_hit) begin
        mask      <= '0;
        link_lost <= 1'b1;
      end
    end
  end

  // Slot contents are only published after all four are rewritten, so no reset.
  always_ff @(posedge clk) begin
    slots <= slots_nxt;
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: vector table, hand-written corner sequences and
// randomized scanning checked every cycle against a sample-history model.
module tb_seg_scan_capture;
  localparam int STABLE  = 4;
  localparam int TIMEOUT = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  seg_sel;
  logic [6:0]  seg_data;
  logic [15:0] digit_data;
  logic        frame_valid, frame_changed, err_pattern, err_select, link_lost;

  seg_scan_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .seg_sel(seg_sel), .seg_data(seg_data),
    .digit_data(digit_data), .frame_valid(frame_valid), .frame_changed(frame_changed),
    .err_pattern(err_pattern), .err_select(err_select), .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] pat_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: a capture happens once a non-blank bus value has been sampled
  // STABLE+1 times in a row; its effect appears on the following edge.
  logic [12:0] run_val;
  int          run_len, since;
  logic [3:0]  m_mask;
  logic [3:0]  m_slot [4];
  logic [15:0] e_dd;
  logic        e_fv, e_fc, e_ep, e_es, e_ll;

  always @(posedge clk or posedge rst) begin : model
    logic [12:0] smp;
    logic [5:0]  sel;
    logic [15:0] newv;
    int lows, idx, val;
    bit ok;
    if (rst) begin
      run_val = '1; run_len = 1; since = 0; m_mask = 0;
      e_dd = 0; e_fv = 0; e_fc = 0; e_ep = 0; e_es = 0; e_ll = 0;
    end else begin
      smp = {seg_sel, seg_data};
      e_fv = 0; e_fc = 0; e_ep = 0; e_es = 0; ok = 0;
      if (run_len == STABLE + 1 && run_val[12:7] != 6'h3F) begin
        sel = run_val[12:7];
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!sel[i]) begin lows++; idx = i; end
        if (lows != 1 || sel[5:4] != 2'b11) begin
          e_es = 1;
        end else begin
          val = -1;
          for (int i = 0; i < 16; i++) if (pat_tab[i] == run_val[6:0]) val = i;
          if (val < 0) e_ep = 1;
          else begin m_slot[idx] = val[3:0]; m_mask[idx] = 1'b1; ok = 1; end
        end
      end
      if (ok) begin
        since = 0;
        if (m_mask == 4'hF) begin
          newv = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
          e_fc = (newv != e_dd); e_fv = 1; e_dd = newv; m_mask = 0; e_ll = 0;
        end
      end else if (since < TIMEOUT) begin
        since++;
        if (since == TIMEOUT) begin m_mask = 0; e_ll = 1; end
      end
      if (smp == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = smp; run_len = 1;
      end
    end
  end

  bit mon_en = 0;
  always @(negedge clk) if (mon_en) begin
    chk("mdl_digit_data", 32'(digit_data), 32'(e_dd));
    chk("mdl_frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("mdl_frame_changed", 32'(frame_changed), 32'(e_fc));
    chk("mdl_err_pattern", 32'(err_pattern), 32'(e_ep));
    chk("mdl_err_select", 32'(err_select), 32'(e_es));
    chk("mdl_link_lost", 32'(link_lost), 32'(e_ll));
  end

  int n_fv, n_fc, n_ep, n_es;
  always @(posedge clk) begin
    #1;
    if (frame_valid) n_fv++;
    if (frame_changed) n_fc++;
    if (err_pattern) n_ep++;
    if (err_select) n_es++;
  end

  task automatic clr_cnt();
    n_fv = 0; n_fc = 0; n_ep = 0; n_es = 0;
  endtask

  // Entered and left on a negedge; nb=0 lets dwells abut.
  task automatic dwell(input logic [5:0] s, input logic [6:0] d, input int n, input int nb);
    seg_sel = s; seg_data = d;
    repeat (n) @(negedge clk);
    seg_sel = 6'h3F; seg_data = 7'h7F;
    repeat (nb) @(negedge clk);
  endtask

  typedef struct {
    logic [5:0] sel; logic [6:0] dat; int dw; int bl;
    int fv; int fc; int ep; int es; logic [15:0] dd;
  } vec_t;
  vec_t vt[$];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [5:0] rs;
    logic [6:0] rd;
    vt.push_back('{6'h3E, 7'h79, 8, 2, 0, 0, 0, 0, 16'h0000});
    vt.push_back('{6'h3D, 7'h24, 8, 2, 0, 0, 0, 0, 16'h0000});
    vt.push_back('{6'h3B, 7'h30, 8, 2, 0, 0, 0, 0, 16'h0000});
    vt.push_back('{6'h37, 7'h19, 8, 2, 1, 1, 0, 0, 16'h4321});
    vt.push_back('{6'h3E, 7'h79, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3D, 7'h24, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3B, 7'h30, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h37, 7'h19, 8, 2, 1, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3E, 7'h7F, 8, 2, 0, 0, 1, 0, 16'h4321});
    vt.push_back('{6'h3E, 7'h7F, 3, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3C, 7'h40, 8, 2, 0, 0, 0, 1, 16'h4321});
    vt.push_back('{6'h1E, 7'h40, 8, 2, 0, 0, 0, 1, 16'h4321});
    vt.push_back('{6'h3C, 7'h40, 3, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3E, 7'h40, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3D, 7'h12, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h3B, 7'h02, 8, 2, 0, 0, 0, 0, 16'h4321});
    vt.push_back('{6'h37, 7'h78, 8, 2, 1, 1, 0, 0, 16'h7650});

    rst = 1'b1; seg_sel = 6'h3F; seg_data = 7'h7F;
    repeat (3) @(negedge clk);
    chk("reset_digit_data", 32'(digit_data), 32'h0);
    chk("reset_pulses", 32'({frame_valid, frame_changed, err_pattern, err_select}), 32'h0);
    chk("reset_link_lost", 32'(link_lost), 32'h0);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);

    foreach (vt[i]) begin
      clr_cnt();
      dwell(vt[i].sel, vt[i].dat, vt[i].dw, vt[i].bl);
      chk($sformatf("vec%0d_fv", i), 32'(n_fv), 32'(vt[i].fv));
      chk($sformatf("vec%0d_fc", i), 32'(n_fc), 32'(vt[i].fc));
      chk($sformatf("vec%0d_ep", i), 32'(n_ep), 32'(vt[i].ep));
      chk($sformatf("vec%0d_es", i), 32'(n_es), 32'(vt[i].es));
      chk($sformatf("vec%0d_dd", i), 32'(digit_data), 32'(vt[i].dd));
    end

    // Latency: last digit first sampled at edge j=0 must publish at edge j=STABLE+1.
    dwell(6'h3D, 7'h24, 8, 2);
    dwell(6'h3B, 7'h30, 8, 2);
    dwell(6'h37, 7'h19, 8, 2);
    seg_sel = 6'h3E; seg_data = 7'h40;
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_fv_edge%0d", j), 32'(frame_valid), 32'(j == STABLE + 1));
      if (j == STABLE + 1) chk("latency_dd", 32'(digit_data), 32'h4320);
    end
    @(negedge clk);
    dwell(6'h3F, 7'h7F, 2, 0);

    // Timeout after a partial frame, then recovery.
    dwell(6'h3E, 7'h40, 8, 2);
    dwell(6'h3D, 7'h79, 8, 2);
    n = 0;
    while (!link_lost && n < 1100) begin @(negedge clk); n++; end
    chk("timeout_link_lost", 32'(link_lost), 32'h1);
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT + STABLE - 8));
    clr_cnt();
    dwell(6'h3B, 7'h30, 8, 2);
    dwell(6'h37, 7'h19, 8, 2);
    chk("timeout_mask_cleared", 32'(n_fv), 32'h0);
    clr_cnt();
    dwell(6'h3E, 7'h12, 8, 2);
    dwell(6'h3D, 7'h02, 8, 2);
    chk("recover_fv", 32'(n_fv), 32'h1);
    chk("recover_link_lost", 32'(link_lost), 32'h0);
    chk("recover_dd", 32'(digit_data), 32'h4365);

    // Reset in the middle of a frame.
    dwell(6'h3E, 7'h79, 8, 2);
    dwell(6'h3D, 7'h24, 8, 2);
    dwell(6'h3B, 7'h30, 8, 2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_dd", 32'(digit_data), 32'h0);
    chk("midrst_pulses", 32'({frame_valid, frame_changed, err_pattern, err_select}), 32'h0);
    chk("midrst_link_lost", 32'(link_lost), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clr_cnt();
    dwell(6'h37, 7'h19, 8, 2);
    chk("midrst_no_frame", 32'(n_fv), 32'h0);

    // Randomized scanning, checked every cycle by the model.
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 9))
        0: rs = 6'($urandom);
        1: rs = 6'h3F;
        default: rs = 6'h3F & ~(6'h01 << $urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 4) == 0) rd = 7'($urandom);
      else rd = pat_tab[$urandom_range(0, 15)];
      dwell(rs, rd, $urandom_range(1, 10), $urandom_range(0, 3));
      if (k == 200) dwell(6'h3F, 7'h7F, TIMEOUT + 20, 0);
    end
    dwell(6'h3F, 7'h7F, 4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
